// File: rtl/fetch_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB with 2-bit counters, RAS-assisted returns.
// Optional performance counters are enabled by defining FETCH_PRED_PERF_EN.
`ifndef XLEN
`define XLEN 32
`endif

module fetch_predictor #(
    parameter int                BTB_ENTRIES = 16,
    parameter int                BTB_IDX_W   = 4,
    parameter logic [`XLEN-1:0]  RESET_PC    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_valid,
    input  logic [`XLEN-1:0]  fetch_pc,
    input  logic [`XLEN-1:0]  ras_top,
    input  logic              ras_valid,
    input  logic              ex_redirect,
    input  logic [`XLEN-1:0]  ex_redirect_pc,
    input  logic              upd_valid,
    input  logic [`XLEN-1:0]  upd_pc,
    input  logic [`XLEN-1:0]  upd_target,
    input  logic              upd_taken,
    input  logic [1:0]        upd_type,
    output logic              pred_valid,
    output logic [`XLEN-1:0]  pred_pc,
    output logic              pred_taken,
    output logic              pred_is_call,
    output logic              pred_is_return
`ifdef FETCH_PRED_PERF_EN
    ,
    output logic [31:0]       perf_lookups,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_redirects
`endif
);

    localparam int TAG_W = `XLEN - BTB_IDX_W - 2;

    localparam logic [1:0] TYPE_BRANCH = 2'b00;
    localparam logic [1:0] TYPE_CALL   = 2'b10;
    localparam logic [1:0] TYPE_RETURN = 2'b11;

    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        else
            return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    logic             r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [`XLEN-1:0] r_target [BTB_ENTRIES];
    logic [1:0]       r_type   [BTB_ENTRIES];
    logic [1:0]       r_ctr    [BTB_ENTRIES];

    logic             r_pred_valid_p1;
    logic [`XLEN-1:0] r_pred_pc_p1;
    logic             r_pred_taken_p1;
    logic             r_pred_call_p1;
    logic             r_pred_ret_p1;

    logic [BTB_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic [1:0]           w_type;
    logic                 w_taken;
    logic [`XLEN-1:0]     w_target;
    logic [`XLEN-1:0]     w_next;
    logic                 w_is_call;
    logic                 w_is_ret;

    logic [BTB_IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]     w_upd_tag;
    logic                 w_upd_hit;
    logic                 w_unused;

    assign w_unused = ^upd_pc[1:0];

    // Lookup stage: combinational from fetch_pc, sees table contents before this cycle's update.
    always_comb begin
        w_idx     = fetch_pc[BTB_IDX_W+1:2];
        w_tag     = fetch_pc[`XLEN-1:BTB_IDX_W+2];
        w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_type    = r_type[w_idx];
        w_taken   = w_hit && ((w_type != TYPE_BRANCH) || (r_ctr[w_idx] >= 2'd2));
        w_target  = r_target[w_idx];
        if (w_type == TYPE_RETURN && ras_valid)
            w_target = ras_top;
        w_next    = w_taken ? w_target : fetch_pc + `XLEN'(4);
        w_is_call = w_hit && (w_type == TYPE_CALL);
        w_is_ret  = w_hit && (w_type == TYPE_RETURN);
    end

    always_comb begin
        w_upd_idx = upd_pc[BTB_IDX_W+1:2];
        w_upd_tag = upd_pc[`XLEN-1:BTB_IDX_W+2];
        w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    end

    // Output register stage (p1): redirect beats stall, stall freezes everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_valid_p1 <= 1'b0;
            r_pred_pc_p1    <= RESET_PC;
            r_pred_taken_p1 <= 1'b0;
            r_pred_call_p1  <= 1'b0;
            r_pred_ret_p1   <= 1'b0;
        end else if (ex_redirect) begin
            r_pred_valid_p1 <= 1'b1;
            r_pred_pc_p1    <= ex_redirect_pc;
            r_pred_taken_p1 <= 1'b0;
            r_pred_call_p1  <= 1'b0;
            r_pred_ret_p1   <= 1'b0;
        end else if (!stall) begin
            r_pred_valid_p1 <= fetch_valid;
            if (fetch_valid) begin
                r_pred_pc_p1    <= w_next;
                r_pred_taken_p1 <= w_taken;
                r_pred_call_p1  <= w_is_call;
                r_pred_ret_p1   <= w_is_ret;
            end else begin
                r_pred_taken_p1 <= 1'b0;
                r_pred_call_p1  <= 1'b0;
                r_pred_ret_p1   <= 1'b0;
            end
        end
    end

    assign pred_valid     = r_pred_valid_p1;
    assign pred_pc        = r_pred_pc_p1;
    assign pred_taken     = r_pred_taken_p1;
    assign pred_is_call   = r_pred_call_p1;
    assign pred_is_return = r_pred_ret_p1;

    // Training: entries become valid only on a taken resolution (hit keeps it valid, miss allocates).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                r_valid[i] <= 1'b0;
        end else if (upd_valid && upd_taken) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= sat_ctr(r_ctr[w_upd_idx], upd_taken);
                if (upd_taken) begin
                    r_target[w_upd_idx] <= upd_target;
                    r_type[w_upd_idx]   <= upd_type;
                end
            end else if (upd_taken) begin
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
                r_type[w_upd_idx]   <= upd_type;
                r_ctr[w_upd_idx]    <= 2'd2;
            end
        end
    end

`ifdef FETCH_PRED_PERF_EN
    logic [31:0] r_perf_lookups;
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_redirects;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lookups   <= '0;
            r_perf_hits      <= '0;
            r_perf_redirects <= '0;
        end else begin
            if (!stall && fetch_valid)
                r_perf_lookups <= r_perf_lookups + 32'd1;
            if (!stall && fetch_valid && w_hit)
                r_perf_hits <= r_perf_hits + 32'd1;
            if (ex_redirect)
                r_perf_redirects <= r_perf_redirects + 32'd1;
        end
    end

    assign perf_lookups   = r_perf_lookups;
    assign perf_hits      = r_perf_hits;
    assign perf_redirects = r_perf_redirects;
`endif

endmodule

// File: tb/tb_fetch_predictor.sv
// Self-checking bench for fetch_predictor: directed vector table plus randomized run against a reference model.
module tb_fetch_predictor;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_valid, ras_valid, ex_redirect, upd_valid, upd_taken;
    logic [31:0] fetch_pc, ras_top, ex_redirect_pc, upd_pc, upd_target;
    logic [1:0]  upd_type;
    logic        pred_valid, pred_taken, pred_is_call, pred_is_return;
    logic [31:0] pred_pc;
`ifdef FETCH_PRED_PERF_EN
    logic [31:0] perf_lookups, perf_hits, perf_redirects;
`endif

    always #5 clk = ~clk;

    fetch_predictor #(.BTB_ENTRIES(16), .BTB_IDX_W(4), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .ras_top(ras_top), .ras_valid(ras_valid), .ex_redirect(ex_redirect),
        .ex_redirect_pc(ex_redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_type(upd_type),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_is_call(pred_is_call), .pred_is_return(pred_is_return)
`ifdef FETCH_PRED_PERF_EN
        , .perf_lookups(perf_lookups), .perf_hits(perf_hits), .perf_redirects(perf_redirects)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a table of BTB entries indexed by pc[5:2], tagged by pc[31:6].
    bit          m_v   [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    logic [1:0]  m_typ [16];
    int          m_ctr [16];
    bit          e_v, e_t, e_c, e_r;
    logic [31:0] e_pc;

    task automatic model_edge();
        int i, u;
        bit hit, tk;
        logic [31:0] tgt, nxt;
        i   = int'(fetch_pc[5:2]);
        hit = m_v[i] && (m_tag[i] == fetch_pc[31:6]);
        tk  = hit && (m_typ[i] != 2'b00 || m_ctr[i] >= 2);
        tgt = (hit && m_typ[i] == 2'b11 && ras_valid) ? ras_top : m_tgt[i];
        nxt = tk ? tgt : fetch_pc + 32'd4;
        if (reset) begin
            e_pc = 32'h100; e_v = 0; e_t = 0; e_c = 0; e_r = 0;
            foreach (m_v[j]) m_v[j] = 0;
        end else begin
            if (ex_redirect) begin
                e_pc = ex_redirect_pc; e_v = 1; e_t = 0; e_c = 0; e_r = 0;
            end else if (!stall) begin
                e_v = fetch_valid;
                if (fetch_valid) begin
                    e_pc = nxt; e_t = tk;
                    e_c = hit && m_typ[i] == 2'b10;
                    e_r = hit && m_typ[i] == 2'b11;
                end else begin
                    e_c = 0; e_r = 0;
                end
            end
            if (upd_valid) begin
                u = int'(upd_pc[5:2]);
                if (m_v[u] && m_tag[u] == upd_pc[31:6]) begin
                    if (upd_taken) begin
                        m_ctr[u] = (m_ctr[u] + 1 > 3) ? 3 : m_ctr[u] + 1;
                        m_tgt[u] = upd_target;
                        m_typ[u] = upd_type;
                    end else begin
                        m_ctr[u] = (m_ctr[u] - 1 < 0) ? 0 : m_ctr[u] - 1;
                    end
                end else if (upd_taken) begin
                    m_v[u] = 1; m_tag[u] = upd_pc[31:6]; m_tgt[u] = upd_target;
                    m_typ[u] = upd_type; m_ctr[u] = 2;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; fetch_valid = 0; fetch_pc = 0; ras_top = 0; ras_valid = 0;
        ex_redirect = 0; ex_redirect_pc = 0; upd_valid = 0; upd_pc = 0; upd_target = 0;
        upd_taken = 0; upd_type = 0;
    endtask

    typedef struct {
        bit          rst, stl, fv;
        logic [31:0] fpc;
        bit          rv;
        logic [31:0] rtop;
        bit          rd;
        logic [31:0] rpc;
        bit          uv;
        logic [31:0] upc, utgt;
        bit          ut;
        logic [1:0]  uty;
        bit          ev;
        logic [31:0] epc;
        bit          et, ec, er;
    } vec_t;

    function automatic vec_t blank();
        vec_t v;
        v = '{rst:0, stl:0, fv:0, fpc:0, rv:0, rtop:0, rd:0, rpc:0, uv:0, upc:0, utgt:0,
              ut:0, uty:0, ev:0, epc:0, et:0, ec:0, er:0};
        return v;
    endfunction

    function automatic vec_t look(logic [31:0] fpc, logic [31:0] epc, bit et, bit ec, bit er);
        vec_t v = blank();
        v.fv = 1; v.fpc = fpc; v.ev = 1; v.epc = epc; v.et = et; v.ec = ec; v.er = er;
        return v;
    endfunction

    function automatic vec_t upd(logic [31:0] pc, logic [31:0] tgt, bit tk, logic [1:0] ty,
                                 logic [31:0] hold_pc);
        vec_t v = blank();
        v.uv = 1; v.upc = pc; v.utgt = tgt; v.ut = tk; v.uty = ty; v.epc = hold_pc;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        vec_t v;
        logic [31:0] p;

        vt.push_back(look(32'h100, 32'h104, 0, 0, 0));
        vt.push_back(upd(32'h40, 32'h80, 1, 2'b00, 32'h104));
        vt.push_back(look(32'h40, 32'h80, 1, 0, 0));
        vt.push_back(upd(32'h40, 32'h0, 0, 2'b00, 32'h80));
        vt.push_back(upd(32'h40, 32'h0, 0, 2'b00, 32'h80));
        vt.push_back(look(32'h40, 32'h44, 0, 0, 0));
        vt.push_back(upd(32'h40, 32'h0, 0, 2'b00, 32'h44));
        vt.push_back(upd(32'h40, 32'h80, 1, 2'b00, 32'h44));
        vt.push_back(look(32'h40, 32'h44, 0, 0, 0));
        vt.push_back(upd(32'h200, 32'h208, 1, 2'b11, 32'h44));
        v = look(32'h200, 32'h1234, 1, 0, 1); v.rv = 1; v.rtop = 32'h1234; vt.push_back(v);
        v = look(32'h200, 32'h208, 1, 0, 1);  v.rv = 0; v.rtop = 32'h1234; vt.push_back(v);
        vt.push_back(upd(32'h300, 32'h500, 1, 2'b10, 32'h208));
        vt.push_back(look(32'h300, 32'h500, 1, 1, 0));
        vt.push_back(look(32'h340, 32'h344, 0, 0, 0));
        v = look(32'h300, 32'hABC0, 0, 0, 0); v.stl = 1; v.rd = 1; v.rpc = 32'hABC0; vt.push_back(v);
        vt.push_back(look(32'h300, 32'h500, 1, 1, 0));
        v = look(32'h40, 32'h500, 1, 1, 0); v.stl = 1; vt.push_back(v);
        v = look(32'h300, 32'h500, 1, 1, 0);
        v.uv = 1; v.upc = 32'h300; v.utgt = 32'h600; v.ut = 1; v.uty = 2'b10; vt.push_back(v);
        vt.push_back(look(32'h300, 32'h600, 1, 1, 0));
        vt.push_back(look(32'hFFFF_FFFC, 32'h0, 0, 0, 0));
        v = upd(32'h400, 32'h700, 1, 2'b01, 32'h100); v.rst = 1; vt.push_back(v);
        vt.push_back(look(32'h400, 32'h404, 0, 0, 0));
        vt.push_back(look(32'h300, 32'h304, 0, 0, 0));

        idle_inputs();
        reset = 1;
        tick();
        tick();
        check("reset.pred_pc", pred_pc, 32'h100);
        check("reset.pred_valid", 32'(pred_valid), 32'd0);
        check("reset.pred_taken", 32'(pred_taken), 32'd0);
        check("reset.hints", {30'd0, pred_is_call, pred_is_return}, 32'd0);

        foreach (vt[i]) begin
            reset = vt[i].rst; stall = vt[i].stl; fetch_valid = vt[i].fv; fetch_pc = vt[i].fpc;
            ras_valid = vt[i].rv; ras_top = vt[i].rtop; ex_redirect = vt[i].rd;
            ex_redirect_pc = vt[i].rpc; upd_valid = vt[i].uv; upd_pc = vt[i].upc;
            upd_target = vt[i].utgt; upd_taken = vt[i].ut; upd_type = vt[i].uty;
            tick();
            check($sformatf("row%0d.valid", i), 32'(pred_valid), 32'(vt[i].ev));
            check($sformatf("row%0d.pc", i), pred_pc, vt[i].epc);
            if (vt[i].ev)
                check($sformatf("row%0d.taken", i), 32'(pred_taken), 32'(vt[i].et));
            check($sformatf("row%0d.call", i), 32'(pred_is_call), 32'(vt[i].ec));
            check($sformatf("row%0d.ret", i), 32'(pred_is_return), 32'(vt[i].er));
        end

        idle_inputs();
        reset = 1;
        tick();
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) < 2);
            stall       = ($urandom_range(0, 99) < 20);
            ex_redirect = ($urandom_range(0, 99) < 10);
            ex_redirect_pc = $urandom & 32'hFFFF_FFFC;
            fetch_valid = ($urandom_range(0, 99) < 80);
            p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 9) == 0) p = $urandom & 32'hFFFF_FFFC;
            fetch_pc    = p;
            ras_valid   = $urandom_range(0, 1);
            ras_top     = $urandom & 32'hFFFF_FFFC;
            upd_valid   = ($urandom_range(0, 99) < 50);
            upd_pc      = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            upd_target  = $urandom & 32'hFFFF_FFFC;
            upd_type    = 2'($urandom_range(0, 3));
            upd_taken   = (upd_type != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            check($sformatf("rnd%0d.valid", n), 32'(pred_valid), 32'(e_v));
            check($sformatf("rnd%0d.pc", n), pred_pc, e_pc);
            if (e_v)
                check($sformatf("rnd%0d.taken", n), 32'(pred_taken), 32'(e_t));
            check($sformatf("rnd%0d.call", n), 32'(pred_is_call), 32'(e_c));
            check($sformatf("rnd%0d.ret", n), 32'(pred_is_return), 32'(e_r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
